// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// Parity framing is enabled by defining SEQ_TX_PARITY_EN.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2,
    ST_DONE = 2'd3
  } seq_tx_state_t;

  localparam int SEQ_TX_WIDTH_DEF  = 8;
  localparam int SEQ_TX_REPS_W_DEF = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register exposing only its MSB.
// A load request takes priority over a shift request.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q_r;

  // Shift register storage; zero fill enters at the LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {WIDTH{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else if (shift) begin
      q_r <= {q_r[WIDTH-2:0], 1'b0};
    end else begin
      q_r <= q_r;
    end
  end

  assign msb = q_r[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first reps+1 times.
// Optional per-frame even-parity bit when SEQ_TX_PARITY_EN is defined.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int WIDTH  = SEQ_TX_WIDTH_DEF,
  parameter int REPS_W = SEQ_TX_REPS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [REPS_W-1:0] reps,
  output logic              busy,
  output logic              w_out,
  output logic              w_valid,
  output logic              frame_end,
  output logic              done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  seq_tx_state_t     state_r, state_nx_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_nx_s;
  logic [REPS_W-1:0] frames_r, frames_nx_s;
  logic [WIDTH-1:0]  pattern_r, pattern_nx_s;
  logic [WIDTH-1:0]  d_s;
  logic              load_s, shift_s, msb_s;
  logic              last_bit_s, more_s;

`ifdef SEQ_TX_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  assign last_bit_s = (bit_cnt_r == LAST_BIT);
  // frames_r counts frames still owed after the current one, so it never wraps.
  assign more_s     = (frames_r != {REPS_W{1'b0}});

  piso_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .shift (shift_s),
    .d     (d_s),
    .msb   (msb_s)
  );

  // State, counter and latched-pattern registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      frames_r  <= {REPS_W{1'b0}};
      pattern_r <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
      frames_r  <= frames_nx_s;
      pattern_r <= pattern_nx_s;
    end
  end

  // Next-state, counter update and shift-register control.
  always_comb begin
    state_nx_s   = state_r;
    bit_cnt_nx_s = bit_cnt_r;
    frames_nx_s  = frames_r;
    pattern_nx_s = pattern_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    d_s          = pattern_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx_s   = ST_SEND;
          pattern_nx_s = pattern;
          frames_nx_s  = reps;
          bit_cnt_nx_s = {CNT_W{1'b0}};
          load_s       = 1'b1;
          d_s          = pattern;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (last_bit_s) begin
          bit_cnt_nx_s = {CNT_W{1'b0}};
`ifdef SEQ_TX_PARITY_EN
          state_nx_s = ST_PAR;
`else
          // Back-to-back frames: reload on the last bit so no gap cycle appears.
          if (more_s) begin
            frames_nx_s = frames_r - REPS_W'(1);
            load_s      = 1'b1;
          end else begin
            state_nx_s = ST_DONE;
          end
`endif
        end else begin
          shift_s      = 1'b1;
          bit_cnt_nx_s = bit_cnt_r + CNT_W'(1);
        end
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PAR: begin
        if (more_s) begin
          frames_nx_s = frames_r - REPS_W'(1);
          load_s      = 1'b1;
          state_nx_s  = ST_SEND;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
`endif
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy      = 1'b0;
    w_valid   = 1'b0;
    w_out     = 1'b0;
    frame_end = 1'b0;
    done      = 1'b0;
    case (state_r)
      ST_SEND: begin
        busy    = 1'b1;
        w_valid = 1'b1;
        w_out   = msb_s;
`ifdef SEQ_TX_PARITY_EN
        frame_end = 1'b0;
`else
        frame_end = last_bit_s;
`endif
      end
      ST_PAR: begin
`ifdef SEQ_TX_PARITY_EN
        busy      = 1'b1;
        w_valid   = 1'b1;
        w_out     = even_parity(pattern_r);
        frame_end = 1'b1;
`else
        busy      = 1'b0;
`endif
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that pairs with the one-hot serial sequence detectors. It latches a WIDTH-bit pattern and a repeat count on `start`, then shifts the pattern out MSB-first on a single-bit `w` stream, one bit per clock. The pattern is sent `reps+1` times back-to-back, and the block signals frame boundaries and completion. It drives the `w` input of detector FSMs in the lab top-levels and benches.

## Interface
- `WIDTH`, default 8: pattern length in bits, ≥2.
- `REPS_W`, default 4: width of the repeat-count input.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request transmission. Sampled only when `busy`=0.
- `pattern` in WIDTH: pattern to send. Latched on accepted `start`.
- `reps` in REPS_W: extra repetitions (frames sent = `reps`+1). Latched with `pattern`.
- `busy` out 1: high while frames are being sent.
- `w_out` out 1: serial data. Forced to 0 when `w_valid`=0.
- `w_valid` out 1: high on every cycle that carries a transmitted bit.
- `frame_end` out 1: high on the last bit of each frame.
- `done` out 1: one-cycle pulse after the final bit of the final frame.

## Operation
- FSM states:
  - IDLE: all outputs 0.
  - SEND: shifting; `busy`=1, `w_valid`=1.
  - PAR: parity bit, present only with PARITY_EN.
  - DONE: `done`=1, `busy`=0, `w_valid`=0.
- IDLE → SEND when `start`=1. `pattern` and `reps` are latched into a shift register and a frame counter on the same edge.
- In SEND, `w_out` = shift register MSB. The register shifts left by one each cycle and the bit counter increments.
- On the last data bit (counter = WIDTH-1):
  - `frame_end`=1.
  - If PARITY_EN: → PAR.
  - Else, if frames remaining: reload the latched pattern and stay in SEND with no gap cycle.
  - Else → DONE.
- DONE → IDLE, or → SEND directly if `start`=1 in the DONE cycle. `busy`=0 in DONE, so `start` is accepted there.
- `start` while `busy`=1 is ignored. Input changes to `pattern`/`reps` during SEND have no effect.
- `reps`=0 sends exactly one frame. `reps` = 2^REPS_W−1 sends 2^REPS_W frames; the counter must not wrap early.
- Bit counter width is $clog2(WIDTH).

## Timing
- Reset values: state IDLE, `busy`=0, `w_out`=0, `w_valid`=0, `frame_end`=0, `done`=0, counters 0.
- Cycle numbering: `start` is accepted at edge 0. Bit k of frame f (k=0 is the MSB) appears in cycle 1 + f·F + k, where F = WIDTH, or WIDTH+1 with parity.
- `done` asserts in cycle (reps+1)·F + 1.
- `busy` is high from cycle 1 through the last bit inclusive.
- All outputs are registered or decoded from registered state only; there is no combinational path from `start` to any output.
- Reset asserted mid-frame: at the next edge the block returns to IDLE and all outputs are 0. The partial frame is abandoned and no `done` is produced.
- Reset and `start` in the same cycle: reset wins.

## Configuration
- `SEQ_TX_PARITY_EN` defined: after each frame's LSB, one PAR cycle sends the even-parity bit (XOR of the pattern).
  - In this mode `frame_end` moves to the parity bit and F = WIDTH+1.
- `SEQ_TX_PARITY_EN` undefined: the PAR state and the parity logic are absent, and F = WIDTH.

## Structure
- Package `seq_tx_pkg` holds:
  - the state typedef and encodings (IDLE, SEND, PAR, DONE);
  - `SEQ_TX_WIDTH_DEF`=8 and `SEQ_TX_REPS_W_DEF`=4.
- One sub-module, `piso_shift_reg`: a WIDTH-bit parallel-load, shift-left register.
  - Ports: `clk`, `reset`, `load`, `shift`, `d`, `msb`.
  - `load` has priority over `shift`.

## Test plan
- WIDTH=8, `pattern`=8'b1011_0010, `reps`=0, `start` pulse at cycle 0:
  - `w_out` = 1,0,1,1,0,0,1,0 in cycles 1–8;
  - `frame_end` in cycle 8 only;
  - `done` in cycle 9; `busy` low from cycle 9.
- Same pattern, `reps`=2: 24 valid bits with no gaps; `frame_end` in cycles 8, 16 and 24; `done` in cycle 25.
- `start` held high with `pattern`=8'hFF during the transfer of 8'b1011_0010: the stream is unchanged. `start` in the DONE cycle (cycle 9) begins a new 8'hFF frame at cycle 10.
- `reset` asserted in cycle 4 of a frame: in cycle 5 all outputs are 0, and no `done` ever appears. A new `start` at cycle 6 yields a clean frame in cycles 7–14.
- With `SEQ_TX_PARITY_EN`:
  - `pattern`=8'b1000_0000: parity bit 1 in cycle 9, `frame_end` in cycle 9, `done` in cycle 10.
  - `pattern`=8'b1011_0010: parity bit 0.
- `reps`=4'hF: exactly 16 `frame_end` pulses before `done`.
